mux4_comportamental: RTL and testbench
======================================

// Module: mux4_comportamental
// PURPOSE
//  - Behavioural 4:1 selector: drives Y from lane D[S] of a 4-lane data bus.
//  - Output is registered on clk (1-cycle latency) with async active-low clear.
//  - Leaf block for datapath/steering logic.
//  - Companion to the combinational mux/demux family, for callers that need a clean registered output.
// PARAMETERS
//  - LANE_W  default 1  width of each data lane; D is 4*LANE_W bits, Y is LANE_W bits
// PORTS
//  - clk    in   1         rising-edge clock
//  - rst_n  in   1         asynchronous, active-low reset
//  - D      in   4*LANE_W  data lanes; lane k = D[k*LANE_W +: LANE_W]
//  - S      in   2         lane select, 2'b00..2'b11
//  - Y      out  LANE_W    registered selected lane
//  - y_chg  out  1         change flag (only with MUX_CHG_FLAG_EN; see CONFIGURATION)
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//  - Reset:
//    - rst_n=0 clears Y to all-zeros immediately, independent of clk.
//    - y_chg is cleared to 0 the same way.
//  - Selection: sel = D[S*LANE_W +: LANE_W]
//    - S=00 -> lane0, S=01 -> lane1, S=10 -> lane2, S=11 -> lane3.
//  - Latency:
//    - On each rising clk edge with rst_n=1, Y <= sel.
//    - Y reflects D/S sampled at the previous edge; exactly 1 cycle.
//  - No handshake. Every cycle is a valid sample. No enable and no hold.
//  - All 4 S codes are legal, so there is no default/error lane.
//    - X/Z on S is not a supported input.
//  - D and S changing together: Y takes the lane chosen by the new S from the new D at the next edge.
//  - Reset mid-operation:
//    - Y goes to 0 asynchronously.
//    - The first edge after rst_n rises loads the current sel. No extra pipeline bubble.
//  - Reset release is synchronised by the integrator, not inside this block.
//  - Unselected lanes have no effect on Y.
// CONFIGURATION
//  - MUX_CHG_FLAG_EN defined:
//    - Adds output y_chg.
//    - At each rising edge with rst_n=1: y_chg <= (sel != Y). This is a 1-cycle pulse, registered alongside the new Y.
//    - y_chg is high in exactly the cycles where Y differs from its previous-cycle value.
//    - y_chg resets to 0.
//    - The first load after reset counts as a change if sel != 0.
//  - MUX_CHG_FLAG_EN undefined:
//    - Port y_chg does not exist.
//    - Logic is the bare registered mux; Y behaviour is identical.
// TESTING
//  - Reset check:
//    - Drive rst_n=0 with D=4'b1111, S=2'b11, clocks running -> Y=0 throughout reset.
//    - y_chg=0 throughout reset.
//  - Lane walk (LANE_W=1):
//    - Drive D=4'b0001; apply S=00,01,10,11 for one cycle each.
//    - Required Y one cycle later: 1,0,0,0.
//    - With MUX_CHG_FLAG_EN: y_chg=1,1,0,0.
//  - Walking one:
//    - D=4'b1000 with S=11 -> Y=1. Change S to 00 -> Y=0 after one edge.
//    - D=4'b0100 with S=10 -> Y=1.
//  - Async reset mid-stream:
//    - With Y=1 (D=4'b0001, S=00), pull rst_n low between edges -> Y=0 before the next edge.
//    - Release rst_n -> Y=1 after the first edge.
//  - Wide lanes (LANE_W=8):
//    - Drive D={8'hDD,8'hCC,8'hBB,8'hAA}; sweep S=00..11.
//    - Required Y: AA,BB,CC,DD, each after one edge.
//  - Simultaneous change:
//    - Set D=4'b0010, S=01 on the same cycle from D=0, S=00 -> next-edge Y=1.
//    - Then hold inputs -> Y stays 1.
//    - With MUX_CHG_FLAG_EN: y_chg=1 for one cycle, then 0.

Source files
------------

// File: rtl/mux4_comportamental_if.sv
// Bus bundle for mux4_comportamental: four data lanes, lane select and
// the registered selected lane.
//
// Optional feature macro: MUX_CHG_FLAG_EN (adds y_chg to the bundle).
//
// Signals
//   D      4*LANE_W  data lanes; lane k = D[k*LANE_W +: LANE_W]
//   S      2         lane select
//   Y      LANE_W    registered selected lane
//   y_chg  1         Y-changed pulse (MUX_CHG_FLAG_EN only)
//
// Modports
//   master  drives D/S, observes Y (and y_chg)
//   slave   the mux itself: takes D/S, drives Y (and y_chg)
interface mux4_comportamental_if #(
    parameter int LANE_W = 1
);
    logic [4*LANE_W-1:0] D;
    logic [1:0]          S;
    logic [LANE_W-1:0]   Y;
`ifdef MUX_CHG_FLAG_EN
    logic                y_chg;

    modport master (output D, output S, input Y, input y_chg);
    modport slave  (input D, input S, output Y, output y_chg);
`else
    modport master (output D, output S, input Y);
    modport slave  (input D, input S, output Y);
`endif
endinterface

// File: rtl/mux4_comportamental.sv
// Registered 4:1 lane selector. Y takes lane D[S] at every rising clk edge
// (one cycle of latency); rst_n clears Y asynchronously.
//
// Optional feature macro: MUX_CHG_FLAG_EN
//   defined   : y_chg pulses for one cycle whenever the newly loaded Y
//               differs from the previous Y (cleared by reset).
//   undefined : bare registered mux, no y_chg.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of mux4_comportamental_if (D, S in; Y, y_chg out)
module mux4_comportamental #(
    parameter int LANE_W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux4_comportamental_if.slave   bus
);

    logic [LANE_W-1:0] w_sel;
    logic [LANE_W-1:0] r_y;

    // All four codes are legal lanes, so the default is never reached in
    // practice; it only keeps the block free of latches.
    always_comb begin
        w_sel = '0;
        case (bus.S)
            2'b00:   w_sel = bus.D[0*LANE_W +: LANE_W];
            2'b01:   w_sel = bus.D[1*LANE_W +: LANE_W];
            2'b10:   w_sel = bus.D[2*LANE_W +: LANE_W];
            2'b11:   w_sel = bus.D[3*LANE_W +: LANE_W];
            default: w_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_sel;
        end
    end

    assign bus.Y = r_y;

`ifdef MUX_CHG_FLAG_EN
    logic r_chg;

    // Compared against the value Y is about to leave, so the pulse lines up
    // with the cycle in which the new Y is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chg <= 1'b0;
        end else begin
            r_chg <= (w_sel != r_y);
        end
    end

    assign bus.y_chg = r_chg;
`endif

endmodule

// File: tb/tb_mux4_comportamental.sv
module tb_mux4_comportamental;

    logic clk;
    logic rst_n;

    mux4_comportamental_if #(.LANE_W(1)) bus1 ();
    mux4_comportamental_if #(.LANE_W(8)) bus8 ();

    mux4_comportamental #(.LANE_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mux4_comportamental #(.LANE_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       y1;
        logic [7:0] y8;
        logic       c1;
        logic       c8;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // reference state: previous expected Y of each instance
    logic       prev1 = 1'b0;
    logic [7:0] prev8 = 8'h00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Issue one cycle of stimulus and push what each DUT must show after the
    // next rising edge.
    task automatic step(input logic [3:0] d1, input logic [1:0] s1,
                        input logic [31:0] d8, input logic [1:0] s8,
                        input logic rst);
        exp_t e;
        logic [3:0]  t1;
        logic [31:0] t8;
        @(negedge clk);
        rst_n   = rst;
        bus1.D  = d1;
        bus1.S  = s1;
        bus8.D  = d8;
        bus8.S  = s8;
        if (!rst) begin
            e.y1 = 1'b0;
            e.y8 = 8'h00;
            e.c1 = 1'b0;
            e.c8 = 1'b0;
        end else begin
            t1   = d1 >> s1;
            t8   = d8 >> (8 * int'(s8));
            e.y1 = t1[0];
            e.y8 = t8[7:0];
            e.c1 = (e.y1 != prev1);
            e.c8 = (e.y8 != prev8);
        end
        prev1 = e.y1;
        prev8 = e.y8;
        q.push_back(e);
    endtask

    // monitor: every cycle is a valid output sample
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("y_lane1", 32'(bus1.Y), 32'(e.y1));
                chk("y_lane8", 32'(bus8.Y), 32'(e.y8));
`ifdef MUX_CHG_FLAG_EN
                chk("chg_lane1", 32'(bus1.y_chg), 32'(e.c1));
                chk("chg_lane8", 32'(bus8.y_chg), 32'(e.c8));
`endif
            end
        end
    end

    localparam logic [31:0] WIDE = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

    initial begin
        rst_n  = 1'b0;
        bus1.D = '0;
        bus1.S = '0;
        bus8.D = '0;
        bus8.S = '0;

        // held in reset with all-ones data and S=11
        repeat (4) step(4'b1111, 2'b11, 32'hFFFF_FFFF, 2'b11, 1'b0);

        // lane walk / wide sweep
        for (int i = 0; i < 4; i++)
            step(4'b0001, 2'(i), WIDE, 2'(i), 1'b1);

        // walking one
        step(4'b1000, 2'b11, WIDE, 2'b11, 1'b1);
        step(4'b1000, 2'b00, WIDE, 2'b00, 1'b1);
        step(4'b0100, 2'b10, WIDE, 2'b10, 1'b1);

        // async reset mid-stream
        step(4'b0001, 2'b00, WIDE, 2'b01, 1'b1);
        step(4'b0001, 2'b00, WIDE, 2'b01, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_y_lane1", 32'(bus1.Y), 32'h0);
        chk("async_y_lane8", 32'(bus8.Y), 32'h0);
`ifdef MUX_CHG_FLAG_EN
        chk("async_chg_lane1", 32'(bus1.y_chg), 32'h0);
        chk("async_chg_lane8", 32'(bus8.y_chg), 32'h0);
`endif
        step(4'b0001, 2'b00, WIDE, 2'b01, 1'b0);
        step(4'b0001, 2'b00, WIDE, 2'b01, 1'b1);
        step(4'b0001, 2'b00, WIDE, 2'b01, 1'b1);

        // simultaneous D/S change, then hold
        step(4'b0000, 2'b00, 32'h0, 2'b00, 1'b1);
        step(4'b0010, 2'b01, WIDE, 2'b11, 1'b1);
        step(4'b0010, 2'b01, WIDE, 2'b11, 1'b1);
        step(4'b0010, 2'b01, WIDE, 2'b11, 1'b1);

        // randomized traffic, with holds and occasional reset
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  d1;
            logic [1:0]  s1;
            logic [31:0] d8;
            logic [1:0]  s8;
            d1 = 4'($urandom);
            s1 = 2'($urandom);
            d8 = $urandom;
            s8 = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                d1 = bus1.D;
                s1 = bus1.S;
                d8 = bus8.D;
                s8 = bus8.S;
            end
            step(d1, s1, d8, s8, ($urandom_range(0, 19) != 0));
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
